// File: rtl/conv_bin2_out_serializer.sv
// conv_bin2_out_serializer
// Captures one binary conv result frame (NK kernel maps of MAPW bits) and
// streams it out one kernel map per valid/ready beat, with a completed-frame
// counter. Optional feature: define CONV_BIN2_SER_POPCNT_EN to add o_popcnt,
// the registered number of ones in the current o_data beat.
module conv_bin2_out_serializer #(
    parameter int NK   = 60,
    parameter int MAPW = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [0:NK*MAPW-1]   i_conv_one_out,
    input  logic                 i_frame_valid,
    output logic                 o_frame_ready,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [0:MAPW-1]      o_data,
    output logic [5:0]           o_kidx,
    output logic                 o_last,
    output logic [15:0]          o_frame_cnt
`ifdef CONV_BIN2_SER_POPCNT_EN
    ,
    output logic [6:0]           o_popcnt
`endif
);

    typedef enum logic {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

    localparam logic [5:0] LAST_IDX = 6'(NK - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [0:NK*MAPW-1]   r_buf;
    logic [5:0]           r_idx;
    logic [0:MAPW-1]      r_data;
    logic                 r_last;
    logic [15:0]          r_frame_cnt;
    logic                 w_cap;
    logic                 w_hs;
    logic [5:0]           w_idx_inc;
    logic [31:0]          w_base;
    logic [0:MAPW-1]      w_next_map;

`ifdef CONV_BIN2_SER_POPCNT_EN
    logic [6:0]           r_popcnt;

    // Number of set bits in one kernel map.
    function automatic logic [6:0] f_popcnt(input logic [0:MAPW-1] d);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < MAPW; i++) begin
            c = c + 7'(d[i]);
        end
        return c;
    endfunction
`endif

    // State register; reset discards any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: flush wins over capture and over the final handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!i_flush && i_frame_valid) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (i_flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_ready && r_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs and qualified events decoded from the current state.
    always_comb begin
        o_frame_ready = (r_state == ST_IDLE);
        o_valid       = (r_state == ST_STREAM);
        w_cap         = (r_state == ST_IDLE) && i_frame_valid && !i_flush;
        w_hs          = (r_state == ST_STREAM) && i_ready && !i_flush;
    end

    // Map for the next beat: kernel 0 straight from the input on capture,
    // otherwise the following kernel from the capture buffer.
    always_comb begin
        w_idx_inc  = r_idx + 6'd1;
        w_base     = 32'(w_idx_inc) * 32'(MAPW);
        w_next_map = '0;
        if (w_cap) begin
            w_next_map = i_conv_one_out[0 +: MAPW];
        end else if (r_idx != LAST_IDX) begin
            w_next_map = r_buf[w_base +: MAPW];
        end
    end

    // Capture buffer, beat index, output beat registers and frame counter.
    // o_data only changes when a new beat is presented, so it holds through
    // stalls and keeps its last value in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf       <= '0;
            r_idx       <= 6'd0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_frame_cnt <= 16'd0;
`ifdef CONV_BIN2_SER_POPCNT_EN
            r_popcnt    <= 7'd0;
`endif
        end else if (w_cap) begin
            r_buf    <= i_conv_one_out;
            r_idx    <= 6'd0;
            r_data   <= w_next_map;
            r_last   <= (LAST_IDX == 6'd0);
`ifdef CONV_BIN2_SER_POPCNT_EN
            r_popcnt <= f_popcnt(w_next_map);
`endif
        end else if (i_flush) begin
            r_idx  <= 6'd0;
            r_last <= 1'b0;
        end else if (w_hs) begin
            if (r_last) begin
                r_idx       <= 6'd0;
                r_last      <= 1'b0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_idx    <= w_idx_inc;
                r_data   <= w_next_map;
                r_last   <= (w_idx_inc == LAST_IDX);
`ifdef CONV_BIN2_SER_POPCNT_EN
                r_popcnt <= f_popcnt(w_next_map);
`endif
            end
        end
    end

    assign o_data      = r_data;
    assign o_kidx      = r_idx;
    assign o_last      = r_last;
    assign o_frame_cnt = r_frame_cnt;
`ifdef CONV_BIN2_SER_POPCNT_EN
    assign o_popcnt    = r_popcnt;
`endif

endmodule
